// File: rtl/sau_result_drain.sv
// Captures a finished systolic-array result matrix plus its tag and drains it row-major, NUM_LANES elements per beat.
// Build option SAU_DRAIN_DBUF_EN adds a second capture buffer so back-to-back results stream without a bubble.
module sau_result_drain #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_LANES   = 1,
    parameter int TAG_WIDTH   = 16,
    localparam int NUM_ELEMS  = MATRIX_SIZE * MATRIX_SIZE,
    localparam int NUM_BEATS  = (NUM_ELEMS + NUM_LANES - 1) / NUM_LANES,
    localparam int BEAT_BITS  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            arr_done,
    input  logic [NUM_ELEMS*DATA_WIDTH-1:0] arr_result,
    input  logic [TAG_WIDTH-1:0]            arr_tag,
    output logic                            busy,
    output logic                            commit_valid,
    input  logic                            commit_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] commit_data,
    output logic [NUM_LANES-1:0]            commit_mask,
    output logic [BEAT_BITS-1:0]            commit_beat,
    output logic                            commit_last,
    output logic [TAG_WIDTH-1:0]            commit_tag,
    output logic                            overflow
);

    localparam int ELEMS_W = NUM_ELEMS * DATA_WIDTH;
    localparam int LANE_W  = NUM_LANES * DATA_WIDTH;
    localparam int PAD_W   = NUM_BEATS * LANE_W;
    localparam int ENTRY_W = ELEMS_W + TAG_WIDTH;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NUM_BEATS - 1);

    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic                 overflow_q, overflow_d;
    logic [ENTRY_W-1:0]   cur_entry;
    logic                 cur_valid;
    logic                 handshake;
    logic                 final_hs;
    logic                 accept;
    logic [PAD_W-1:0]     padded;

    // commit_valid/commit_ready: a beat transfers on any cycle both are high; the
    // payload is a pure function of registered state, so it holds steady while stalled.
    assign handshake = cur_valid && commit_ready;
    assign final_hs  = handshake && (beat_q == LAST_BEAT);

`ifdef SAU_DRAIN_DBUF_EN
    logic [1:0][ENTRY_W-1:0] buf_q, buf_d;
    logic [1:0]              full_q, full_d;
    logic                    rd_q, rd_d;
    logic                    wr_sel;

    // rd_q always names the older buffer, so it is occupied whenever either one is.
    assign cur_valid = full_q[rd_q];
    assign cur_entry = buf_q[rd_q];
    assign busy      = &full_q;
    assign accept    = !(&full_q) || final_hs;
    assign wr_sel    = (full_q[rd_q] && !full_q[~rd_q]) ? ~rd_q : rd_q;

    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        rd_d   = rd_q;
        if (final_hs) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
        if (arr_done && accept) begin
            buf_d[wr_sel]  = {arr_tag, arr_result};
            full_d[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
`else
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [ENTRY_W-1:0] buf_q, buf_d;

    assign cur_valid = (state_q == DRAIN);
    assign cur_entry = buf_q;
    assign busy      = cur_valid;
    assign accept    = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (arr_done) begin
                    buf_d   = {arr_tag, arr_result};
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (final_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
`endif

    always_comb begin
        beat_d = beat_q;
        if (!cur_valid || final_hs) begin
            beat_d = '0;
        end else if (handshake) begin
            beat_d = beat_q + 1'b1;
        end
        overflow_d = overflow_q | (arr_done & ~accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    // Zero padding past NUM_ELEMS makes the lanes of a partial final beat read as 0.
    always_comb begin
        padded                = '0;
        padded[ELEMS_W-1:0]   = cur_entry[ELEMS_W-1:0];
        commit_valid          = cur_valid;
        commit_data           = '0;
        commit_mask           = '0;
        commit_beat           = '0;
        commit_last           = 1'b0;
        commit_tag            = '0;
        if (cur_valid) begin
            commit_data = padded[int'(beat_q) * LANE_W +: LANE_W];
            for (int l = 0; l < NUM_LANES; l++) begin
                commit_mask[l] = ((int'(beat_q) * NUM_LANES + l) < NUM_ELEMS);
            end
            commit_beat = beat_q;
            commit_last = (beat_q == LAST_BEAT);
            commit_tag  = cur_entry[ENTRY_W-1 -: TAG_WIDTH];
        end
    end

endmodule

// File: doc/sau_result_drain.md
Name: sau_result_drain

Overview:
- Response-side counterpart of the SAU request path.
- The systolic array signals completion with a `done` pulse. This block captures the full result matrix together with the request tag.
- It then serialises the matrix row-major, NUM_LANES elements per beat, onto a valid/ready commit interface toward writeback.
- It back-pressures the SAU via `busy` so that no new matrix operation starts while a result is still pending.

Parameters:
- MATRIX_SIZE, 2: matrix dimension; NUM_ELEMS = MATRIX_SIZE*MATRIX_SIZE.
- DATA_WIDTH, 32: width of one result element.
- NUM_LANES, 1: elements emitted per commit beat; 1..NUM_ELEMS.
- TAG_WIDTH, 16: opaque request tag (wid/rd/PC index) returned with every beat.
- Derived:
  - NUM_BEATS = ceil(NUM_ELEMS/NUM_LANES).
  - BEAT_BITS = max(1, clog2(NUM_BEATS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arr_done  in  1  single-cycle pulse: arr_result is valid this cycle.
- arr_result  in  NUM_ELEMS*DATA_WIDTH  result matrix, element e = row*MATRIX_SIZE+col at bits [e*DATA_WIDTH +: DATA_WIDTH].
- arr_tag  in  TAG_WIDTH  tag of the operation, sampled with arr_done.
- busy  out  1  high while a result is held; SAU must not assert start.
- commit_valid  out  1  beat available.
- commit_ready  in  1  consumer accepts beat.
- commit_data  out  NUM_LANES*DATA_WIDTH  beat payload; lane l = element beat*NUM_LANES+l.
- commit_mask  out  NUM_LANES  lane valid bits; zero lanes past NUM_ELEMS.
- commit_beat  out  BEAT_BITS  beat index.
- commit_last  out  1  final beat of matrix.
- commit_tag  out  TAG_WIDTH  captured tag.
- overflow  out  1  sticky: arr_done arrived with no free buffer.

Behaviour:
- Reset values: busy=0, commit_valid=0, commit_data=0, commit_mask=0, commit_beat=0, commit_last=0, commit_tag=0, overflow=0. Reset mid-drain discards the held matrix; no partial beats are emitted afterwards.
- FSM states:
  - IDLE: on arr_done, capture arr_result and arr_tag, clear beat counter, go to DRAIN. commit_valid rises the following cycle (1-cycle capture latency). busy rises the same cycle as commit_valid.
  - DRAIN:
    - commit_valid=1.
    - Outputs are registered and stable while commit_valid && !commit_ready.
    - On a handshake (valid&&ready): if beat==NUM_BEATS-1, go to IDLE and drop commit_valid and busy next cycle. Otherwise increment beat and present the next beat next cycle; commit_valid stays high.
- Back-to-back throughput: one beat per cycle when commit_ready is held high.
- commit_last = (beat==NUM_BEATS-1) while valid.
- commit_mask lane l = (beat*NUM_LANES+l < NUM_ELEMS). Unmasked lanes carry 0.
- arr_done while in DRAIN (no free buffer): the result is dropped, overflow sets and stays set until reset, and the current drain is unaffected.
- arr_done on the same cycle as the final handshake: treated as overflow (buffer not yet free) in the base configuration.
- No arithmetic on data; elements pass through bit-exact.

Optional Feature:
- SAU_DRAIN_DBUF_EN
- Defined:
  - Two capture buffers in ping-pong.
  - arr_done is accepted whenever at least one buffer is free, including the cycle of the final handshake of the other buffer.
  - After the last beat of buffer A, commit_valid stays high and beat 0 of buffer B is presented on the next cycle (no bubble).
  - busy = both buffers occupied.
  - overflow only when both are occupied and no final handshake occurs that cycle.
- Undefined: single buffer, behaviour as above.

Test Plan:
- MATRIX_SIZE=2, NUM_LANES=1: arr_done with elements {0x11,0x22,0x33,0x44}, tag 0x00A5, commit_ready=1 -> 4 consecutive beats starting the cycle after done, data 0x11,0x22,0x33,0x44, beat 0..3, last only on beat 3, tag 0x00A5 every beat; busy high exactly those 4 cycles.
- Same matrix, commit_ready toggled 1,0,0,1,... -> each beat held stable across stalls, no element skipped or duplicated, last on 4th accepted beat.
- MATRIX_SIZE=3, NUM_LANES=4 -> 3 beats; masks 4'b1111, 4'b1111, 4'b0001; beat 2 lanes 1..3 are zero.
- Second arr_done during DRAIN (base build) -> overflow=1 sticky, first matrix drained intact, second never emitted; with SAU_DRAIN_DBUF_EN -> overflow stays 0 and 8 beats are emitted with no gap.
- reset asserted after beat 1 accepted -> next cycle commit_valid=0, busy=0; new arr_done afterwards drains from beat 0.
